// File: rtl/op_seq_pkg.sv
// -----------------------------------------------------------------------------
// op_seq_pkg
// Shared definitions for the operation sequencer:
//   - op_seq_state_e     : sequencer FSM state encoding
//   - OP_SEQ_MAX_LATENCY : largest supported operand read latency
//   - clip_count()       : limits a requested element count to the memory depth
// -----------------------------------------------------------------------------
package op_seq_pkg;

    localparam int OP_SEQ_MAX_LATENCY = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } op_seq_state_e;

    // A run never touches more elements than the memory holds.
    function automatic int unsigned clip_count(input int unsigned count,
                                               input int unsigned depth);
        return (count > depth) ? depth : count;
    endfunction

endpackage

// File: rtl/op_seq_addr_gen.sv
// -----------------------------------------------------------------------------
// op_seq_addr_gen
// Element index generator for the operation sequencer. Loads the start index
// and element count of a run, steps to the next element each time a write is
// committed, and flags when the element in flight is the last one.
//
// Ports:
//   clk_i      in  1     clock
//   rst_i      in  1     asynchronous active-high reset
//   load_i     in  1     capture base_i/count_i (accepted start)
//   base_i     in  AW    first element index
//   count_i    in  AW+1  element count, already clipped to MEM_DEPTH
//   advance_i  in  1     current element committed; move to the next
//   idx_o      out AW    current element index
//   last_o     out 1     current element is the final one of the run
// -----------------------------------------------------------------------------
module op_seq_addr_gen #(
    parameter int MEM_DEPTH = 8,
    parameter int AW        = $clog2(MEM_DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic [AW-1:0] base_i,
    input  logic [AW:0]   count_i,
    input  logic          advance_i,
    output logic [AW-1:0] idx_o,
    output logic          last_o
);

    localparam int CW = AW + 1;

    logic [AW-1:0] idx;
    logic [CW-1:0] remaining;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from the same pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx       <= '0;
            remaining <= '0;
        end else if (load_i) begin
            idx       <= base_i;
            remaining <= count_i;
        end else if (advance_i) begin
            // Index is exactly AW bits wide, so it wraps modulo MEM_DEPTH.
            idx       <= idx + 1'b1;
            remaining <= remaining - 1'b1;
        end
    end

    assign idx_o  = idx;
    assign last_o = (remaining == CW'(1));

endmodule

// File: rtl/op_sequencer.sv
// -----------------------------------------------------------------------------
// op_sequencer
// Sequencing controller for the operation datapath. On an accepted start it
// walks a window of element indices: it issues a shared read address to both
// operand memories, waits the operand read latency, then writes the result
// memory at the same index, one element at a time. A commit counter and a
// stall input let a lockstep checker compare every committed result before
// the sequence moves on.
//
// Ports:
//   clk_i         in  1     clock
//   rst_i         in  1     asynchronous active-high reset
//   start_i       in  1     run request, sampled only in IDLE
//   base_addr_i   in  AW    first element index
//   count_i       in  AW+1  elements to process (clipped to MEM_DEPTH)
//   stall_i       in  1     hold request
//   busy_o        out 1     run in progress, including the DONE cycle
//   done_o        out 1     one-cycle completion pulse
//   rd_en_o       out 1     operand read strobe
//   rd_addr_o     out AW    shared operand address
//   op_valid_o    out 1     operands valid; datapath result consumed
//   wr_en_o       out 1     result memory write strobe
//   wr_addr_o     out AW    result address
//   commit_cnt_o  out AW+1  results written in the current/last run
// -----------------------------------------------------------------------------
module op_sequencer
    import op_seq_pkg::*;
#(
    parameter int MEM_DEPTH  = 8,
    parameter int MEM_WIDTH  = 32,
    parameter int RD_LATENCY = 1,
    localparam int AW        = $clog2(MEM_DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [AW-1:0] base_addr_i,
    input  logic [AW:0]   count_i,
    input  logic          stall_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          rd_en_o,
    output logic [AW-1:0] rd_addr_o,
    output logic          op_valid_o,
    output logic          wr_en_o,
    output logic [AW-1:0] wr_addr_o,
    output logic [AW:0]   commit_cnt_o
);

    localparam int CW        = AW + 1;
    localparam int WAIT_W    = $clog2(OP_SEQ_MAX_LATENCY);
    // WAIT lasts RD_LATENCY-1 cycles; the counter runs down to zero.
    localparam int WAIT_LOAD = (RD_LATENCY > 1) ? RD_LATENCY - 2 : 0;

    if (MEM_DEPTH < 2 || (MEM_DEPTH & (MEM_DEPTH - 1)) != 0 || MEM_WIDTH < 1 ||
        RD_LATENCY < 1 || RD_LATENCY > OP_SEQ_MAX_LATENCY) begin : g_param_error
        $error("op_sequencer: parameter out of range");
    end

    op_seq_state_e state;
    op_seq_state_e next_state;

    logic [CW-1:0]     count_clipped;
    logic              start_accept;
    logic              advance;
    logic [AW-1:0]     idx;
    logic              last;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CW-1:0]     commit_cnt;

    assign count_clipped = CW'(clip_count(32'(count_i), 32'(MEM_DEPTH)));
    assign start_accept  = (state == ST_IDLE) && start_i;
    assign advance       = (state == ST_WRITE) && !stall_i;

    op_seq_addr_gen #(
        .MEM_DEPTH (MEM_DEPTH),
        .AW        (AW)
    ) u_addr_gen (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (start_accept),
        .base_i    (base_addr_i),
        .count_i   (count_clipped),
        .advance_i (advance),
        .idx_o     (idx),
        .last_o    (last)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave it unassigned and infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    next_state = (count_clipped == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!stall_i) begin
                    next_state = (RD_LATENCY > 1) ? ST_WAIT : ST_WRITE;
                end
            end
            ST_WAIT: begin
                if (!stall_i && wait_cnt == '0) begin
                    next_state = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!stall_i) begin
                    next_state = last ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Wait counter is loaded as the read leaves ISSUE and frozen by stall.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_cnt <= '0;
        end else if (state == ST_ISSUE && !stall_i) begin
            wait_cnt <= WAIT_W'(WAIT_LOAD);
        end else if (state == ST_WAIT && !stall_i && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            commit_cnt <= '0;
        end else if (start_accept) begin
            commit_cnt <= '0;
        end else if (advance) begin
            commit_cnt <= commit_cnt + 1'b1;
        end
    end

    // Outputs decode the registered state. The read/write strobes are the one
    // exception: they are qualified by stall_i so a held ISSUE/WRITE fires its
    // strobe exactly once, in the first unstalled cycle.
    always_comb begin
        busy_o     = (state != ST_IDLE);
        done_o     = (state == ST_DONE);
        rd_en_o    = (state == ST_ISSUE) && !stall_i;
        rd_addr_o  = (state == ST_ISSUE) ? idx : '0;
        wr_en_o    = advance;
        op_valid_o = advance;
        wr_addr_o  = (state == ST_WRITE) ? idx : '0;
    end

    assign commit_cnt_o = commit_cnt;

endmodule

// File: tb/tb_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_op_sequencer
// Self-checking bench for op_sequencer. Two instances (read latency 1 and 3)
// share the same stimulus. A reference model turns every accepted start into
// a script of per-cycle slots (read, wait, write, done); stall holds the slot
// at the head of the script. A negedge compare process checks every output of
// both instances against that script each cycle, and directed scenarios pin
// the observed write/done cycle numbers to hand-computed literals.
// -----------------------------------------------------------------------------
module tb_op_sequencer;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int CW    = 4;

    localparam int K_ISSUE = 1;
    localparam int K_WAIT  = 2;
    localparam int K_WRITE = 3;
    localparam int K_DONE  = 4;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [AW-1:0] base_i;
    logic [CW-1:0] count_i;
    logic          stall_i;

    logic          busy     [2];
    logic          done     [2];
    logic          rd_en    [2];
    logic [AW-1:0] rd_addr  [2];
    logic          op_valid [2];
    logic          wr_en    [2];
    logic [AW-1:0] wr_addr  [2];
    logic [CW-1:0] commit   [2];

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference script per instance
    int m_kind [2][64];
    int m_addr [2][64];
    int m_head [2];
    int m_tail [2];
    int m_commit [2];
    int start_cyc [2];

    // DUT observations since the last accepted start (cycle numbers relative
    // to the start cycle)
    int obs_wr_n     [2];
    int obs_wr_rel   [2][16];
    int obs_wr_addr  [2][16];
    int obs_rd_n     [2];
    int obs_done_n   [2];
    int obs_done_rel [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    op_sequencer #(.MEM_DEPTH(DEPTH), .MEM_WIDTH(32), .RD_LATENCY(1)) u_dut_l1 (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .base_addr_i  (base_i),
        .count_i      (count_i),
        .stall_i      (stall_i),
        .busy_o       (busy[0]),
        .done_o       (done[0]),
        .rd_en_o      (rd_en[0]),
        .rd_addr_o    (rd_addr[0]),
        .op_valid_o   (op_valid[0]),
        .wr_en_o      (wr_en[0]),
        .wr_addr_o    (wr_addr[0]),
        .commit_cnt_o (commit[0])
    );

    op_sequencer #(.MEM_DEPTH(DEPTH), .MEM_WIDTH(32), .RD_LATENCY(3)) u_dut_l3 (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .base_addr_i  (base_i),
        .count_i      (count_i),
        .stall_i      (stall_i),
        .busy_o       (busy[1]),
        .done_o       (done[1]),
        .rd_en_o      (rd_en[1]),
        .rd_addr_o    (rd_addr[1]),
        .op_valid_o   (op_valid[1]),
        .wr_en_o      (wr_en[1]),
        .wr_addr_o    (wr_addr[1]),
        .commit_cnt_o (commit[1])
    );

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int i, input int kind, input int addr);
        m_kind[i][m_tail[i]] = kind;
        m_addr[i][m_tail[i]] = addr;
        m_tail[i]++;
    endtask

    // Build the cycle script of one run: per element a read slot, L-1 wait
    // slots and a write slot, then a single done slot.
    task automatic build_run(input int i, input int base, input int count);
        int n;
        n = (count > DEPTH) ? DEPTH : count;
        m_head[i] = 0;
        m_tail[i] = 0;
        for (int e = 0; e < n; e++) begin
            push(i, K_ISSUE, (base + e) % DEPTH);
            for (int w = 1; w < lat_of(i); w++) push(i, K_WAIT, 0);
            push(i, K_WRITE, (base + e) % DEPTH);
        end
        push(i, K_DONE, 0);
        m_commit[i] = 0;
    endtask

    // Compare process: outputs are settled and inputs stable at the negedge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int    k;
            int    rel;
            bit    e_busy, e_done, e_rd, e_wr;
            int    e_rd_a, e_wr_a, e_commit;
            string tag;
            k = 0; e_busy = 0; e_done = 0; e_rd = 0; e_wr = 0;
            e_rd_a = 0; e_wr_a = 0;
            rel = cyc - start_cyc[i];
            tag = $sformatf("L%0d", lat_of(i));
            e_commit = rst_i ? 0 : m_commit[i];
            if (!rst_i && m_head[i] != m_tail[i]) begin
                k = m_kind[i][m_head[i]];
                e_busy = 1'b1;
                if (k == K_ISSUE && !stall_i) begin
                    e_rd = 1'b1;
                    e_rd_a = m_addr[i][m_head[i]];
                end
                if (k == K_WRITE && !stall_i) begin
                    e_wr = 1'b1;
                    e_wr_a = m_addr[i][m_head[i]];
                end
                if (k == K_DONE) e_done = 1'b1;
            end
            check({tag, " busy"},     int'(busy[i]),     int'(e_busy));
            check({tag, " done"},     int'(done[i]),     int'(e_done));
            check({tag, " rd_en"},    int'(rd_en[i]),    int'(e_rd));
            check({tag, " wr_en"},    int'(wr_en[i]),    int'(e_wr));
            check({tag, " op_valid"}, int'(op_valid[i]), int'(e_wr));
            check({tag, " commit"},   int'(commit[i]),   e_commit);
            if (e_rd) check({tag, " rd_addr"}, int'(rd_addr[i]), e_rd_a);
            if (e_wr) check({tag, " wr_addr"}, int'(wr_addr[i]), e_wr_a);
            if (rst_i) begin
                check({tag, " rd_addr in reset"}, int'(rd_addr[i]), 0);
                check({tag, " wr_addr in reset"}, int'(wr_addr[i]), 0);
            end

            if (wr_en[i] && obs_wr_n[i] < 16) begin
                obs_wr_rel[i][obs_wr_n[i]]  = rel;
                obs_wr_addr[i][obs_wr_n[i]] = int'(wr_addr[i]);
                obs_wr_n[i]++;
            end
            if (rd_en[i]) obs_rd_n[i]++;
            if (done[i]) begin
                obs_done_n[i]++;
                obs_done_rel[i] = rel;
            end

            // Advance the model to what the next edge produces.
            if (rst_i) begin
                m_head[i]   = 0;
                m_tail[i]   = 0;
                m_commit[i] = 0;
            end else if (m_head[i] != m_tail[i]) begin
                if (e_wr) m_commit[i]++;
                if (k == K_DONE || !stall_i) m_head[i]++;
            end else if (start_i) begin
                build_run(i, int'(base_i), int'(count_i));
                start_cyc[i]    = cyc;
                obs_wr_n[i]     = 0;
                obs_rd_n[i]     = 0;
                obs_done_n[i]   = 0;
                obs_done_rel[i] = -1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input int base, input int count);
        start_i = 1'b1;
        base_i  = AW'(base);
        count_i = CW'(count);
        step(1);
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!(m_head[0] == m_tail[0] && m_head[1] == m_tail[1]) && n < budget) begin
            step(1);
            n++;
        end
        if (n >= budget) check("idle timeout", 0, 1);
    endtask

    // Hand-computed expectations for one finished run of instance i.
    task automatic expect_run(input string name, input int i, input int n_wr,
                              input int first_rel, input int last_rel,
                              input int done_rel, input int first_addr);
        check({name, " write count"}, obs_wr_n[i], n_wr);
        check({name, " done pulses"}, obs_done_n[i], 1);
        check({name, " done cycle"},  obs_done_rel[i], done_rel);
        check({name, " commit_cnt"},  int'(commit[i]), n_wr);
        if (n_wr > 0 && obs_wr_n[i] == n_wr) begin
            check({name, " first write cycle"}, obs_wr_rel[i][0], first_rel);
            check({name, " last write cycle"},  obs_wr_rel[i][n_wr-1], last_rel);
            for (int e = 0; e < n_wr; e++)
                check($sformatf("%s write addr %0d", name, e), obs_wr_addr[i][e],
                      (first_addr + e) % DEPTH);
        end
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; stall_i = 1'b0; base_i = '0; count_i = '0;
        for (int i = 0; i < 2; i++) begin
            m_head[i] = 0; m_tail[i] = 0; m_commit[i] = 0; start_cyc[i] = 0;
            obs_wr_n[i] = 0; obs_rd_n[i] = 0; obs_done_n[i] = 0; obs_done_rel[i] = -1;
        end
        step(3);
        rst_i = 1'b0;
        step(2);
        check("reset busy L1", int'(busy[0]), 0);
        check("reset commit L3", int'(commit[1]), 0);

        // Basic run
        pulse_start(0, 8);
        wait_idle(100);
        expect_run("basic L1", 0, 8, 2, 16, 17, 0);
        expect_run("basic L3", 1, 8, 4, 32, 33, 0);

        // Wrap and latency (back-to-back start in first IDLE cycle)
        pulse_start(6, 4);
        wait_idle(100);
        expect_run("wrap L3", 1, 4, 4, 16, 17, 6);
        expect_run("wrap L1", 0, 4, 2, 8, 9, 6);

        // Zero count
        pulse_start(3, 0);
        wait_idle(100);
        expect_run("zero L1", 0, 0, 0, 0, 1, 0);
        check("zero L1 reads", obs_rd_n[0], 0);
        check("zero L3 reads", obs_rd_n[1], 0);

        // Clipped count
        pulse_start(0, 12);
        wait_idle(100);
        expect_run("clip L1", 0, 8, 2, 16, 17, 0);

        // Stall for 3 cycles starting at the write of element 1
        pulse_start(0, 3);
        step(3);
        stall_i = 1'b1;
        step(3);
        stall_i = 1'b0;
        wait_idle(100);
        expect_run("stall L1", 0, 3, 2, 9, 10, 0);
        check("stall L1 elem1 write cycle", obs_wr_rel[0][1], 7);
        expect_run("stall L3", 1, 3, 7, 15, 16, 0);

        // Start while busy is ignored
        pulse_start(0, 8);
        step(4);
        pulse_start(4, 8);
        wait_idle(100);
        expect_run("busy start L1", 0, 8, 2, 16, 17, 0);

        // Asynchronous reset mid-run, between edges of cycle 9
        pulse_start(0, 8);
        step(8);
        check("pre-reset commit L1", int'(commit[0]), 4);
        rst_i = 1'b1;
        #1;
        check("async reset busy L1",   int'(busy[0]),   0);
        check("async reset wr_en L1",  int'(wr_en[0]),  0);
        check("async reset rd_en L1",  int'(rd_en[0]),  0);
        check("async reset commit L1", int'(commit[0]), 0);
        check("async reset busy L3",   int'(busy[1]),   0);
        step(2);
        rst_i = 1'b0;
        step(10);
        check("idle after reset L1", int'(busy[0]), 0);

        // Randomized traffic: starts, stalls and occasional resets
        for (int c = 0; c < 1500; c++) begin
            start_i = ($urandom % 6 == 0);
            base_i  = AW'($urandom % DEPTH);
            count_i = CW'($urandom_range(0, 12));
            stall_i = ($urandom % 4 == 0);
            rst_i   = ($urandom % 400 == 0);
            step(1);
        end
        start_i = 1'b0;
        stall_i = 1'b0;
        rst_i   = 1'b0;
        wait_idle(200);
        step(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
